// File: rtl/bcd_sched_pkg.sv
// Shared types and helpers for the BCD request scheduler.
// Optional feature macro: BCD_BLANK_EN (leading-zero blanking of bcd_out).
package bcd_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // Digit code the display encoders render as all segments off
  localparam logic [3:0] BCD_BLANK = 4'hF;

  // Number of BCD digits needed to hold a w-bit binary operand
  function automatic int unsigned bcd_digits(input int unsigned w);
    return (w + (w - 4) / 3 + 4) / 4;
  endfunction

endpackage

// File: rtl/bin2bcd.sv
// Combinational double-dabble binary to packed-BCD converter.
module bin2bcd
  import bcd_sched_pkg::*;
#(
  parameter int unsigned W = 10
) (
  input  logic [W-1:0]                bin,
  output logic [4*bcd_digits(W)-1:0]  bcd
);

  localparam int unsigned DIG = bcd_digits(W);

  // Shift in one operand bit per step, correcting digits >= 5 beforehand
  always_comb begin
    bcd = '0;
    for (int i = int'(W) - 1; i >= 0; i--) begin
      for (int d = 0; d < int'(DIG); d++) begin
        if (bcd[4*d +: 4] >= 4'd5) bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
      end
      bcd = {bcd[4*DIG-2:0], bin[i]};
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after rr_ptr wins.
module rr_arbiter #(
  parameter int unsigned N_REQ = 3
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] rr_ptr,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] grant_idx,
  output logic                     any
);

  localparam int unsigned IW = $clog2(N_REQ);

  // Search upward from the pointer, wrapping modulo N_REQ
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      if (!any && req[(32'(rr_ptr) + 32'(k)) % N_REQ]) begin
        grant_idx = IW'((32'(rr_ptr) + 32'(k)) % N_REQ);
        grant     = N_REQ'(1) << grant_idx;
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_req_scheduler.sv
// Round-robin scheduler sharing one bin2bcd converter among N_REQ requesters.
// Optional feature macro: BCD_BLANK_EN (blank leading zero digits with 4'hF).
module bcd_req_scheduler
  import bcd_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned W     = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ*W-1:0]           bin,
  output logic [N_REQ-1:0]             ack,
  output logic [4*bcd_digits(W)-1:0]   bcd_out,
  output logic                         bcd_valid,
  output logic [$clog2(N_REQ)-1:0]     bcd_id,
  output logic                         busy
);

  localparam int unsigned DIG = bcd_digits(W);
  localparam int unsigned BW  = 4 * DIG;
  localparam int unsigned IW  = $clog2(N_REQ);

  state_t           state_q, state_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]    id_q, id_d;
  logic [IW-1:0]    bcd_id_q, bcd_id_d;
  logic [IW-1:0]    gnt_idx;
  logic [W-1:0]     op_q, op_d, gnt_op;
  logic [BW-1:0]    conv_bcd, bcd_fmt, bcd_q, bcd_d;
  logic [N_REQ-1:0] gnt, ack_q, ack_d;
  logic             valid_q, valid_d, gnt_any;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req       (req),
    .rr_ptr    (rr_ptr_q),
    .grant     (gnt),
    .grant_idx (gnt_idx),
    .any       (gnt_any)
  );

  bin2bcd #(.W(W)) u_conv (
    .bin (op_q),
    .bcd (conv_bcd)
  );

  // AND-OR select of the granted requester's operand
  always_comb begin
    gnt_op = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (gnt[i]) gnt_op = gnt_op | bin[i*W +: W];
    end
  end

`ifdef BCD_BLANK_EN
  logic lead;

  // Replace leading zero digits by the blank code; ones digit always shown
  always_comb begin
    bcd_fmt = conv_bcd;
    lead    = 1'b1;
    for (int d = int'(DIG) - 1; d > 0; d--) begin
      if (lead && conv_bcd[4*d +: 4] == 4'd0) bcd_fmt[4*d +: 4] = BCD_BLANK;
      else                                    lead = 1'b0;
    end
  end
`else
  assign bcd_fmt = conv_bcd;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: IDLE -> CONV on any request, then DONE, then IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_any) state_d = CONV;
      CONV:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: latch operand on grant, register result and ack pulse
  always_comb begin
    op_d     = op_q;
    id_d     = id_q;
    rr_ptr_d = rr_ptr_q;
    bcd_d    = bcd_q;
    bcd_id_d = bcd_id_q;
    ack_d    = '0;
    valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          op_d = gnt_op;
          id_d = gnt_idx;
        end
      end
      CONV: begin
        bcd_d    = bcd_fmt;
        bcd_id_d = id_q;
        ack_d    = N_REQ'(1) << id_q;
        valid_d  = 1'b1;
      end
      DONE: begin
        rr_ptr_d = (id_q == IW'(N_REQ - 1)) ? '0 : id_q + IW'(1);
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      id_q     <= '0;
      rr_ptr_q <= '0;
      bcd_q    <= '0;
      bcd_id_q <= '0;
      ack_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      op_q     <= op_d;
      id_q     <= id_d;
      rr_ptr_q <= rr_ptr_d;
      bcd_q    <= bcd_d;
      bcd_id_q <= bcd_id_d;
      ack_q    <= ack_d;
      valid_q  <= valid_d;
    end
  end

  assign ack       = ack_q;
  assign bcd_valid = valid_q;
  assign bcd_out   = bcd_q;
  assign bcd_id    = bcd_id_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_bcd_req_scheduler.sv
// Self-checking bench for bcd_req_scheduler (N_REQ=3, W=10).
// Honours BCD_BLANK_EN the same way as the design build.
module tb_bcd_req_scheduler;

  localparam int unsigned N   = 3;
  localparam int unsigned W   = 10;
  localparam int unsigned DIG = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*W-1:0]   bin;
  logic [N-1:0]     ack;
  logic [4*DIG-1:0] bcd_out;
  logic             bcd_valid;
  logic [1:0]       bcd_id;
  logic             busy;

  int n_vec = 0;
  int n_err = 0;

  bcd_req_scheduler #(.N_REQ(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .bin       (bin),
    .ack       (ack),
    .bcd_out   (bcd_out),
    .bcd_valid (bcd_valid),
    .bcd_id    (bcd_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: rising edge, then settle to the falling edge for drive/sample
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_bin(input int i, input int v);
    bin[i*W +: W] = W'(v);
  endtask

  // Decimal digits by plain division, then optional leading-zero blanking
  function automatic logic [15:0] ref_bcd(input int v);
    logic [15:0] r;
    int x;
    x = v;
    r = '0;
    for (int d = 0; d < 4; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
`ifdef BCD_BLANK_EN
    for (int d = 3; d > 0; d--) begin
      if (r[4*d +: 4] != 4'd0) break;
      r[4*d +: 4] = 4'hF;
    end
`endif
    return r;
  endfunction

  // Single requester: IDLE (req seen), CONV, DONE with ack; operand changed after grant
  task automatic serve_single(input int idx, input int val, input int late,
                              input logic [15:0] exp, input string nm);
    set_bin(idx, val);
    req[idx] = 1'b1;
    tick();
    check({nm, " busy in CONV"}, 32'(busy), 1);
    check({nm, " no ack at grant"}, 32'(ack), 0);
    set_bin(idx, late);
    tick();
    check({nm, " ack"}, 32'(ack), 32'(1) << idx);
    check({nm, " valid"}, 32'(bcd_valid), 1);
    check({nm, " bcd_out"}, 32'(bcd_out), 32'(exp));
    check({nm, " bcd_id"}, 32'(bcd_id), 32'(idx));
    req[idx] = 1'b0;
    tick();
    check({nm, " ack drop"}, 32'(ack), 0);
    check({nm, " valid drop"}, 32'(bcd_valid), 0);
    check({nm, " idle"}, 32'(busy), 0);
    check({nm, " bcd_out hold"}, 32'(bcd_out), 32'(exp));
  endtask

  typedef struct {
    int          idx;
    int          val;
    logic [15:0] exp_plain;
    logic [15:0] exp_blank;
  } vec_t;

  vec_t tbl[6];

  bit   pend[N];
  int   opv[N];
  int   mptr;
  int   e;
  int   seen;
  bit   got;
  int   exp_order[4];
  int   exp_val[N];

  initial begin
    tbl[0] = '{0, 123,  16'h0123, 16'hF123};
    tbl[1] = '{1, 0,    16'h0000, 16'hFFF0};
    tbl[2] = '{0, 7,    16'h0007, 16'hFFF7};
    tbl[3] = '{1, 1023, 16'h1023, 16'h1023};
    tbl[4] = '{0, 999,  16'h0999, 16'hF999};
    tbl[5] = '{2, 40,   16'h0040, 16'hFF40};

    rst = 1'b1;
    req = '0;
    bin = '0;
    @(negedge clk);
    tick();
    check("reset ack", 32'(ack), 0);
    check("reset valid", 32'(bcd_valid), 0);
    check("reset bcd_out", 32'(bcd_out), 0);
    check("reset bcd_id", 32'(bcd_id), 0);
    check("reset busy", 32'(busy), 0);
    rst = 1'b0;
    tick();

    // Table of single conversions; operand scrambled after each grant
    for (int i = 0; i < 6; i++) begin
`ifdef BCD_BLANK_EN
      serve_single(tbl[i].idx, tbl[i].val, tbl[i].val ^ 'h155, tbl[i].exp_blank, $sformatf("tbl%0d", i));
`else
      serve_single(tbl[i].idx, tbl[i].val, tbl[i].val ^ 'h155, tbl[i].exp_plain, $sformatf("tbl%0d", i));
`endif
    end

    // All three held: acks 0,1,2,0 spaced three cycles apart
    exp_val[0] = 5; exp_val[1] = 999; exp_val[2] = 1023;
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 2; exp_order[3] = 0;
    for (int i = 0; i < 3; i++) set_bin(i, exp_val[i]);
    req  = 3'b111;
    seen = 0;
    for (int c = 1; c <= 11; c++) begin
      tick();
      if (ack != 0) begin
        if (seen < 4) begin
          check("rr ack order", 32'(ack), 32'(1) << exp_order[seen]);
          check("rr ack cycle", 32'(c), 32'(2 + 3 * seen));
          check("rr bcd_out", 32'(bcd_out), 32'(ref_bcd(exp_val[exp_order[seen]])));
        end
        seen++;
      end
    end
    check("rr ack count", 32'(seen), 4);
    req = '0;
    tick();

    // Operand change one cycle after grant is ignored
    serve_single(1, 42, 77, ref_bcd(42), "late bin");

    // Reset during CONV aborts; held request is served afterwards
    set_bin(0, 321);
    req[0] = 1'b1;
    tick();
    check("abort in CONV", 32'(busy), 1);
    rst = 1'b1;
    tick();
    check("abort ack", 32'(ack), 0);
    check("abort valid", 32'(bcd_valid), 0);
    check("abort bcd_out", 32'(bcd_out), 0);
    check("abort bcd_id", 32'(bcd_id), 0);
    check("abort busy", 32'(busy), 0);
    rst = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 6 && !got; c++) begin
      tick();
      if (ack != 0) begin
        got = 1'b1;
        check("reserve ack", 32'(ack), 1);
        check("reserve bcd_out", 32'(bcd_out), 32'(ref_bcd(321)));
      end
    end
    check("reserve seen", 32'(got), 1);
    req = '0;
    tick();

    // req[2] pulses only while busy with requester 0: never served
    set_bin(0, 12);
    req[0] = 1'b1;
    tick();
    set_bin(2, 888);
    req[2] = 1'b1;
    tick();
    check("pulse ack0", 32'(ack), 1);
    req = '0;
    tick();
    check("pulse busy falls", 32'(busy), 0);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("pulse no ack", 32'(ack), 0);
      check("pulse stays idle", 32'(busy), 0);
    end

    // Random traffic against a pending-set model
    rst = 1'b1;
    req = '0;
    tick();
    rst  = 1'b0;
    mptr = 0;
    for (int i = 0; i < int'(N); i++) pend[i] = 1'b0;
    for (int it = 0; it < 240; it++) begin
      if (!(pend[0] || pend[1] || pend[2])) begin
        for (int i = 0; i < int'(N); i++) begin
          if ($urandom_range(1, 0) == 1 || (i == int'(N) - 1 && !(pend[0] || pend[1]))) begin
            pend[i] = 1'b1;
            opv[i]  = int'($urandom_range(1023, 0));
            set_bin(i, opv[i]);
            req[i]  = 1'b1;
          end
        end
      end
      e = -1;
      for (int k = 0; k < int'(N); k++) begin
        if (e < 0 && pend[(mptr + k) % int'(N)]) e = (mptr + k) % int'(N);
      end
      got = 1'b0;
      for (int c = 0; c < 8 && !got; c++) begin
        tick();
        check("rand ack onehot0", 32'($countones(ack) <= 1), 1);
        if (ack != 0) got = 1'b1;
      end
      if (!got) begin
        n_vec++;
        n_err++;
        $display("FAIL rand ack timeout: got none expected id %0d", e);
        break;
      end
      check("rand ack", 32'(ack), 32'(1) << e);
      check("rand valid", 32'(bcd_valid), 1);
      check("rand bcd_id", 32'(bcd_id), 32'(e));
      check("rand bcd_out", 32'(bcd_out), 32'(ref_bcd(opv[e])));
      pend[e] = 1'b0;
      req[e]  = 1'b0;
      mptr    = (e + 1) % int'(N);
      for (int i = 0; i < int'(N); i++) begin
        if (!pend[i]) begin
          if ($urandom_range(2, 0) == 0) begin
            pend[i] = 1'b1;
            opv[i]  = int'($urandom_range(1023, 0));
            set_bin(i, opv[i]);
            req[i]  = 1'b1;
          end else begin
            set_bin(i, int'($urandom_range(1023, 0)));
          end
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
